// File: rtl/score_pkg.sv
// Shared types and widths for the score controller and its helpers.
package score_pkg;

    localparam int SCORE_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Clamp a one-bit-wider sum to the ceiling; the extra bit keeps the add from wrapping.
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W:0] sum,
                                                     input logic [SCORE_W:0] ceiling);
        if (sum > ceiling)
            return ceiling[SCORE_W-1:0];
        return sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Time-point divider: counts 0..CLK_DIV-1 while enabled and flags the terminal count.
module tick_divider #(
    parameter int CLK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Holding while disabled lets a paused game resume mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/score_controller.sv
// Game score keeper: FSM, time-point scoring, round-robin bonus grants, high score.
module score_controller
    import score_pkg::*;
#(
    parameter int CLK_DIV   = 50000000,
    parameter int MAX_SCORE = 9999,
    parameter int BONUS0    = 10,
    parameter int BONUS1    = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               game_over,
    input  logic [1:0]         bonus_req,
    output logic [1:0]         bonus_ack,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [1:0]         state
);

    localparam logic [SCORE_W:0] CEIL = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [SCORE_W:0] B0   = (SCORE_W+1)'(BONUS0);
    localparam logic [SCORE_W:0] B1   = (SCORE_W+1)'(BONUS1);

    state_t           state_q, state_d;
    logic             last_q;
    logic [1:0]       grant;
    logic             tick;
    logic             new_game, end_game, run_live;
    logic [SCORE_W:0] inc, sum;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: if (start && !game_over) state_d = ST_RUN;
            ST_RUN: begin
                if (game_over)  state_d = ST_OVER;
                else if (pause) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (game_over)   state_d = ST_OVER;
                else if (!pause) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign new_game = (state_q == ST_IDLE || state_q == ST_OVER) && state_d == ST_RUN;
    assign end_game = (state_q == ST_RUN || state_q == ST_PAUSE) && game_over;
    // The game_over cycle awards nothing, so grants are withheld too rather than acked for free.
    assign run_live = (state_q == ST_RUN) && !game_over;

    always_comb begin
        grant = 2'b00;
        if (run_live) begin
            if (bonus_req == 2'b11)
                grant = last_q ? 2'b01 : 2'b10;
            else
                grant = bonus_req;
        end
    end

    assign inc = (SCORE_W+1)'(tick) + (grant[0] ? B0 : '0) + (grant[1] ? B1 : '0);
    assign sum = {1'b0, score} + inc;

    tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .clear  (new_game),
        .enable (state_q == ST_RUN),
        .tick   (tick)
    );

    // last_q=1 means requester 1 was granted last, so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            bonus_ack  <= 2'b00;
            score      <= '0;
            high_score <= '0;
        end else begin
            state_q   <= state_d;
            bonus_ack <= grant;
            if (grant[0]) last_q <= 1'b0;
            if (grant[1]) last_q <= 1'b1;
            if (new_game)
                score <= '0;
            else if (run_live)
                score <= sat_score(sum, CEIL);
            if (end_game && score > high_score)
                high_score <= score;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed + randomized bench for score_controller against a cycle-level game model.
module tb_score_controller;

    localparam int CLK_DIV   = 4;
    localparam int MAX_SCORE = 9999;
    localparam int BONUS0    = 10;
    localparam int BONUS1    = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, game_over = 1'b0;
    logic [1:0]  bonus_req = 2'b00;
    logic [1:0]  bonus_ack, state;
    logic [13:0] score, high_score;

    int checks = 0;
    int errors = 0;

    // Reference model: game state (0..3), score, best score, divider phase, last winner, ack pulse.
    int m_state, m_score, m_high, m_div, m_last, m_ack;

    always #5 clk = ~clk;

    score_controller #(
        .CLK_DIV(CLK_DIV), .MAX_SCORE(MAX_SCORE), .BONUS0(BONUS0), .BONUS1(BONUS1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .game_over(game_over),
        .bonus_req(bonus_req), .bonus_ack(bonus_ack), .score(score),
        .high_score(high_score), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".score"}, 32'(score), 32'(m_score));
        chk({tag, ".high"},  32'(high_score), 32'(m_high));
        chk({tag, ".ack"},   32'(bonus_ack), 32'(m_ack));
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_div = 0; m_last = 1; m_ack = 0;
    endtask

    // One clock of the game rules, evaluated from the inputs currently driven.
    task automatic model_step();
        int tick, g, inc;
        m_ack = 0;
        case (m_state)
            0, 3: if (start && !game_over) begin m_state = 1; m_score = 0; m_div = 0; end
            1: begin
                tick  = (m_div == CLK_DIV - 1) ? 1 : 0;
                m_div = (m_div + 1) % CLK_DIV;
                if (game_over) begin
                    if (m_score > m_high) m_high = m_score;
                    m_state = 3;
                end else begin
                    if (bonus_req == 2'b11)      g = (m_last == 1) ? 0 : 1;
                    else if (bonus_req == 2'b01) g = 0;
                    else if (bonus_req == 2'b10) g = 1;
                    else                         g = -1;
                    inc = tick + (g == 0 ? BONUS0 : 0) + (g == 1 ? BONUS1 : 0);
                    if (g >= 0) begin m_ack = 1 << g; m_last = g; end
                    m_score = (m_score + inc > MAX_SCORE) ? MAX_SCORE : m_score + inc;
                    if (pause) m_state = 2;
                end
            end
            default: begin
                if (game_over) begin
                    if (m_score > m_high) m_high = m_score;
                    m_state = 3;
                end else if (!pause) m_state = 1;
            end
        endcase
    endtask

    task automatic step(input logic [1:0] req, input logic st, input logic pa, input logic go,
                        input string tag);
        bonus_req = req; start = st; pause = pa; game_over = go;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int frozen;
        logic [1:0] rr_exp [4];
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Requests in IDLE are ignored.
        for (int i = 0; i < 5; i++) step(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, "idle_req");

        // Start, then 40 plain RUN cycles: one point every CLK_DIV cycles.
        step(2'b00, 1'b1, 1'b0, 1'b0, "start");
        for (int i = 0; i < 40; i++) step(2'b00, 1'b0, 1'b0, 1'b0, "run40");
        chk("run40_score", 32'(score), 32'd10);
        chk("run40_state", 32'(state), 32'd1);

        // Both requesters held: strict alternation starting with requester 0.
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b0, 1'b0, 1'b0, "rr");
            chk("rr_seq", 32'(bonus_ack), 32'(rr_exp[i]));
        end

        // Random play with occasional pauses.
        for (int i = 0; i < 200; i++)
            step(2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 7) == 0), 1'b0, "rand");
        step(2'b00, 1'b0, 1'b0, 1'b0, "unpause");
        step(2'b00, 1'b0, 1'b0, 1'b0, "unpause");

        // First game over: requests in the final cycle earn nothing.
        frozen = m_score;
        step(2'b11, 1'b0, 1'b0, 1'b1, "go1");
        chk("go1_state", 32'(state), 32'd3);
        chk("go1_high", 32'(high_score), 32'(frozen));
        for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 1'b0, "over_req");

        step(2'b00, 1'b1, 1'b0, 1'b0, "start2");
        chk("start2_score", 32'(score), 32'd0);
        chk("start2_high", 32'(high_score), 32'(frozen));

        // Pause while the divider sits mid-period; resume completes that period.
        for (int i = 0; i < 8 && m_div != 1; i++) step(2'b00, 1'b0, 1'b0, 1'b0, "align");
        step(2'b00, 1'b0, 1'b1, 1'b0, "pause_in");
        frozen = m_score;
        for (int i = 0; i < 10; i++) step(2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0, "paused");
        chk("pause_frozen", 32'(score), 32'(frozen));
        step(2'b00, 1'b0, 1'b0, 1'b0, "resume");
        step(2'b00, 1'b0, 1'b0, 1'b0, "resume1");
        chk("resume_no_tick", 32'(score), 32'(frozen));
        step(2'b00, 1'b0, 1'b0, 1'b0, "resume2");
        chk("resume_tick", 32'(score), 32'(frozen + 1));

        // Drive to the ceiling with requester 1 and keep ticking past it.
        for (int i = 0; i < 600 && m_score < 9990; i++) step(2'b10, 1'b0, 1'b0, 1'b0, "climb");
        for (int i = 0; i < 3; i++) step(2'b10, 1'b0, 1'b0, 1'b0, "sat_grant");
        chk("sat_score", 32'(score), 32'(MAX_SCORE));
        for (int i = 0; i < 12; i++) step(2'b11, 1'b0, 1'b0, 1'b0, "sat_hold");
        chk("sat_hold_score", 32'(score), 32'(MAX_SCORE));

        step(2'b00, 1'b0, 1'b0, 1'b1, "go2");
        chk("go2_high", 32'(high_score), 32'(MAX_SCORE));

        // A worse game leaves the best score alone.
        step(2'b00, 1'b1, 1'b0, 1'b0, "start3");
        for (int i = 0; i < 15; i++) step(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, "g3");
        step(2'b00, 1'b0, 1'b0, 1'b1, "go3");
        chk("go3_high", 32'(high_score), 32'(MAX_SCORE));

        // Reset mid-game clears everything without waiting for a clock.
        step(2'b00, 1'b1, 1'b0, 1'b0, "start4");
        for (int i = 0; i < 15; i++) step(2'b01, 1'b0, 1'b0, 1'b0, "g4");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2'b00, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
